// File: rtl/dac_stream_buffer.sv
// Prime-then-stream FIFO between experiment words and the RF DAC sample port.
// Optional saturating underrun counter enabled by defining DAC_UNDERRUN_CNT_EN.
module dac_stream_buffer #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned PRIME_LVL = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stream_en,
    input  logic [255:0]            s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [255:0]            m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [$clog2(DEPTH):0]  fill_level,
`ifdef DAC_UNDERRUN_CNT_EN
    output logic [15:0]             underrun_count,
`endif
    output logic                    underrun_flag
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StPrime, StStream} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     fill_q, fill_d;
    logic            flag_q, flag_d;
    logic [255:0]    mem_q [DEPTH];

    logic            full, empty, push, pop, underrun, clear_stats;

    assign full     = (fill_q == (AW+1)'(DEPTH));
    assign empty    = (fill_q == '0);
    assign push     = s_axis_tvalid && s_axis_tready;
    assign pop      = (state_q == StStream) && !empty && m_axis_tready;
    assign underrun = (state_q == StStream) && empty && m_axis_tready;

    assign s_axis_tready = !full && (state_q != StIdle);
    assign m_axis_tvalid = (state_q == StStream);
    assign m_axis_tdata  = (state_q == StStream && !empty) ? mem_q[rd_ptr_q] : '0;
    assign fill_level    = fill_q;
    assign underrun_flag = flag_q;

    assign clear_stats = (state_q == StIdle) && stream_en;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        flag_d   = flag_q;

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      fill_d = fill_q + (AW+1)'(1);
        else if (pop && !push) fill_d = fill_q - (AW+1)'(1);

        if (underrun)    flag_d = 1'b1;
        if (clear_stats) flag_d = 1'b0;

        case (state_q)
            StIdle:   if (stream_en) state_d = StPrime;
            // Uses the post-edge fill so tvalid rises the cycle after the priming push.
            StPrime:  if (fill_d >= (AW+1)'(PRIME_LVL)) state_d = StStream;
            StStream: state_d = StStream;
            default:  state_d = StIdle;
        endcase

        if (!stream_en) begin
            state_d  = StIdle;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            flag_q   <= flag_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= s_axis_tdata;
    end

`ifdef DAC_UNDERRUN_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (underrun && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        if (clear_stats) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign underrun_count = cnt_q;
`endif

endmodule

// File: tb/tb_dac_stream_buffer.sv
// Directed bench for dac_stream_buffer (DEPTH=8, PRIME_LVL=4).
// Counter checks are active when DAC_UNDERRUN_CNT_EN is defined.
module tb_dac_stream_buffer;

    logic         clk = 1'b0;
    logic         rst;
    logic         stream_en;
    logic [255:0] s_axis_tdata;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic [255:0] m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic [3:0]   fill_level;
    logic         underrun_flag;
`ifdef DAC_UNDERRUN_CNT_EN
    logic [15:0]  underrun_count;
`endif

    int tests = 0;
    int fails = 0;

    always #2 clk = ~clk;

    dac_stream_buffer #(.DEPTH(8), .PRIME_LVL(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .stream_en     (stream_en),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .fill_level    (fill_level),
`ifdef DAC_UNDERRUN_CNT_EN
        .underrun_count(underrun_count),
`endif
        .underrun_flag (underrun_flag)
    );

    function automatic logic [255:0] word(input int unsigned i);
        return {8{32'hD0C0_0000 | i}};
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [255:0] q[$];
    logic [255:0] exp_d;
    int  sent, rcv, cyc;
    bit  mstream, v, r, do_push, do_pop;

    initial begin
        rst = 1'b1; stream_en = 1'b0; s_axis_tdata = '0; s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        step();
        check("rst_s_ready", s_axis_tready, 0);
        check("rst_m_valid", m_axis_tvalid, 0);
        check("rst_m_data", m_axis_tdata, 0);
        check("rst_fill", fill_level, 0);
        check("rst_flag", underrun_flag, 0);
`ifdef DAC_UNDERRUN_CNT_EN
        check("rst_cnt", underrun_count, 0);
`endif
        rst = 1'b0;
        step();
        check("idle_s_ready", s_axis_tready, 0);

        // Prime with four words, then stream them out
        stream_en = 1'b1;
        step();
        check("prime_s_ready", s_axis_tready, 1);
        check("prime_m_valid", m_axis_tvalid, 0);
        m_axis_tready = 1'b1; s_axis_tvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_axis_tdata = word(i);
            step();
            if (i < 3) begin
                check("prime_hold_valid", m_axis_tvalid, 0);
                check("prime_hold_data", m_axis_tdata, 0);
                check("prime_hold_fill", fill_level, i + 1);
            end
        end
        s_axis_tvalid = 1'b0;
        check("stream_valid", m_axis_tvalid, 1);
        check("stream_w0", m_axis_tdata, word(0));
        check("stream_fill4", fill_level, 4);
        for (int i = 1; i < 4; i++) begin
            step();
            check("stream_wn", m_axis_tdata, word(i));
            check("stream_fill", fill_level, 4 - i);
        end
        step();
        check("empty_fill", fill_level, 0);
        check("empty_data", m_axis_tdata, 0);
        check("empty_valid", m_axis_tvalid, 1);
        check("empty_noflag", underrun_flag, 0);

        // Three underrun cycles
        for (int k = 1; k <= 3; k++) begin
            step();
            check("ur_flag", underrun_flag, 1);
            check("ur_data", m_axis_tdata, 0);
            check("ur_valid", m_axis_tvalid, 1);
`ifdef DAC_UNDERRUN_CNT_EN
            check("ur_cnt", underrun_count, k);
`endif
        end

        // Data resumes without re-priming
        m_axis_tready = 1'b0; s_axis_tvalid = 1'b1; s_axis_tdata = word(4);
        step();
        s_axis_tvalid = 1'b0;
        check("resume_data", m_axis_tdata, word(4));
        check("resume_fill", fill_level, 1);
        m_axis_tready = 1'b1;
        step();
        m_axis_tready = 1'b0;
        check("resume_drain", fill_level, 0);

        // Fill to capacity; extra words refused
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_axis_tdata = word(10 + ((i < 8) ? i : 8));
            step();
        end
        check("full_fill", fill_level, 8);
        check("full_s_ready", s_axis_tready, 0);
        check("full_head", m_axis_tdata, word(10));
        m_axis_tready = 1'b1;
        step();
        check("full_pop_fill", fill_level, 7);
        check("full_pop_head", m_axis_tdata, word(11));
        check("full_pop_ready", s_axis_tready, 1);
        m_axis_tready = 1'b0;
        step();
        check("refill_fill", fill_level, 8);
        s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
        for (int i = 11; i <= 18; i++) begin
            check("full_order", m_axis_tdata, word(i));
            step();
        end
        m_axis_tready = 1'b0;
        check("full_drained", fill_level, 0);

        // Stop mid-stream with five words buffered
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_axis_tdata = word(30 + i);
            step();
        end
        s_axis_tvalid = 1'b0;
        check("stop_pre_fill", fill_level, 5);
        check("stop_pre_head", m_axis_tdata, word(30));
        stream_en = 1'b0;
        step();
        check("stop_fill", fill_level, 0);
        check("stop_valid", m_axis_tvalid, 0);
        check("stop_s_ready", s_axis_tready, 0);
        check("stop_data", m_axis_tdata, 0);
        check("stop_flag_sticky", underrun_flag, 1);
        stream_en = 1'b1;
        step();
        check("rearm_flag_clr", underrun_flag, 0);
`ifdef DAC_UNDERRUN_CNT_EN
        check("rearm_cnt_clr", underrun_count, 0);
`endif
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_axis_tdata = word(40 + i);
            step();
        end
        s_axis_tvalid = 1'b0;
        check("rst_pre_fill", fill_level, 5);
        check("rst_pre_valid", m_axis_tvalid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_fill", fill_level, 0);
        check("mid_rst_valid", m_axis_tvalid, 0);
        check("mid_rst_s_ready", s_axis_tready, 0);
        check("mid_rst_data", m_axis_tdata, 0);
        step();
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s_axis_tdata = word(50 + i);
            step();
        end
        s_axis_tvalid = 1'b0;
        check("reprime_valid", m_axis_tvalid, 0);
        check("reprime_data", m_axis_tdata, 0);
        check("reprime_fill", fill_level, 2);
        stream_en = 1'b0;
        step();
        stream_en = 1'b1;
        step();

        // Random valid/ready, 100 words through the wrapping pointers
        sent = 0; rcv = 0; cyc = 0; mstream = 1'b0;
        while (rcv < 100 && cyc < 3000) begin
            v = (sent < 100) && ($urandom_range(0, 3) != 0);
            r = mstream && (q.size() > 0) && ($urandom_range(0, 2) != 0);
            s_axis_tvalid = v;
            s_axis_tdata  = v ? word(200 + sent) : '0;
            m_axis_tready = r;
            #0;
            exp_d = (mstream && q.size() > 0) ? q[0] : '0;
            check("wrap_s_ready", s_axis_tready, (q.size() < 8) ? 1 : 0);
            check("wrap_m_valid", m_axis_tvalid, mstream);
            check("wrap_data", m_axis_tdata, exp_d);
            do_push = v && (q.size() < 8);
            do_pop  = r;
            step();
            cyc++;
            if (do_pop) begin
                void'(q.pop_front());
                rcv++;
            end
            if (do_push) begin
                q.push_back(word(200 + sent));
                sent++;
            end
            if (!mstream && q.size() >= 4) mstream = 1'b1;
        end
        s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
        check("wrap_count", rcv, 100);
        check("wrap_no_underrun", underrun_flag, 0);
        check("wrap_fill_end", fill_level, q.size());

        // Long underrun run
        m_axis_tready = 1'b1;
        step();
        check("long_ur_flag", underrun_flag, 1);
`ifdef DAC_UNDERRUN_CNT_EN
        check("long_ur_cnt1", underrun_count, 1);
        repeat (65534) step();
        check("sat_cnt_hit", underrun_count, 16'hFFFF);
        repeat (4465) step();
        check("sat_cnt_hold", underrun_count, 16'hFFFF);
`endif
        m_axis_tready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
